// File: rtl/radix4_booth_multiplier.sv
// Sequential 32x32 signed multiplier using radix-4 Booth recoding.
// One operation takes 35 cycles from start acceptance to the return to IDLE.
module radix4_booth_multiplier (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        start,
  input  logic [31:0] X,
  input  logic [31:0] Y,
  output logic        busy,
  output logic        done,
  output logic [63:0] product
);

  // Handshake: start is a request that is taken only on an edge where the
  // FSM sits in IDLE (busy=0); X and Y are captured on that same edge.
  // The start, X and Y inputs are not looked at again until the next IDLE.
  typedef enum logic [4:0] {
    IDLE  = 5'b00001,
    LOAD  = 5'b00010,
    ADD   = 5'b00100,
    SHIFT = 5'b01000,
    DONE  = 5'b10000
  } state_t;

  state_t      state;
  logic [31:0] x_cap;
  logic [31:0] y_cap;
  logic [33:0] a;
  logic [33:0] m;
  logic [31:0] q;
  logic        q_m1;
  logic [3:0]  cnt;

  logic [33:0] mag;
  logic        neg;
  logic [33:0] addend;
  logic [33:0] a_sum;
  logic [68:0] shift_in;
  logic [66:0] shifted;

  // Booth digit selection from the low multiplier pair plus the previous bit.
  always_comb begin
    mag = '0;
    neg = 1'b0;
    case ({q[1:0], q_m1})
      3'b001, 3'b010: begin mag = m;               neg = 1'b0; end
      3'b011:         begin mag = {m[32:0], 1'b0}; neg = 1'b0; end
      3'b100:         begin mag = {m[32:0], 1'b0}; neg = 1'b1; end
      3'b101, 3'b110: begin mag = m;               neg = 1'b1; end
      default:        begin mag = '0;              neg = 1'b0; end
    endcase
  end

  // Subtraction is A + ~D + 1; the carry out of bit 33 is simply dropped.
  always_comb begin
    addend   = neg ? ~mag : mag;
    a_sum    = a + addend + {33'd0, neg};
    shift_in = {a[33], a[33], a, q, q_m1};
    shifted  = shift_in[68:2];
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state   <= IDLE;
      x_cap   <= '0;
      y_cap   <= '0;
      a       <= '0;
      m       <= '0;
      q       <= '0;
      q_m1    <= 1'b0;
      cnt     <= '0;
      product <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            x_cap <= X;
            y_cap <= Y;
            state <= LOAD;
            busy  <= 1'b1;
          end else begin
            busy <= 1'b0;
          end
        end
        LOAD: begin
          a     <= '0;
          q     <= y_cap;
          q_m1  <= 1'b0;
          m     <= {{2{x_cap[31]}}, x_cap};
          cnt   <= '0;
          state <= ADD;
        end
        ADD: begin
          a     <= a_sum;
          state <= SHIFT;
        end
        SHIFT: begin
          a    <= shifted[66:33];
          q    <= shifted[32:1];
          q_m1 <= shifted[0];
          cnt  <= cnt + 4'd1;
          if (cnt == 4'd15) begin
            // The low 64 bits of the 66-bit {A,Q} hold the full product.
            product <= {shifted[64:33], shifted[32:1]};
            done    <= 1'b1;
            state   <= DONE;
          end else begin
            state <= ADD;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/radix4_booth_multiplier.md
RADIX4_BOOTH_MULTIPLIER -- requirements
Module: radix4_booth_multiplier

Interface
REQ-001 The block SHALL have no parameters; operand width is fixed at 32 bits.
REQ-002 clk  input  1  clock; all state changes on the rising edge.
REQ-003 rst_b  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 X  input  32  multiplicand, signed two's complement; captured on the edge that accepts start.
REQ-006 Y  input  32  multiplier, signed two's complement; captured on the edge that accepts start.
REQ-007 busy  output  1  high in every state except IDLE.
REQ-008 done  output  1  single-cycle completion pulse.
REQ-009 product  output  64  signed product X*Y, registered.

Function
REQ-010 The FSM SHALL have the states IDLE, LOAD, ADD, SHIFT and DONE, with one-hot encoding.
REQ-011 IDLE SHALL go to LOAD when start=1 and SHALL otherwise stay in IDLE.
REQ-012 LOAD SHALL set the following registers and then go to ADD:
- A (34 bit) = 0
- Q (32 bit) = captured Y
- q_m1 = 0
- M (34 bit) = captured X sign-extended
- cnt (4 bit) = 0
REQ-013 ADD SHALL update A = A + D, where D is selected by {Q[1],Q[0],q_m1}:
- 000 or 111: 0
- 001 or 010: +M
- 011: +2M
- 100: -2M
- 101 or 110: -M
REQ-014 Subtraction in ADD SHALL be done as A + ~D + 1 in 34-bit two's complement, and carry-out SHALL be discarded.
REQ-015 ADD SHALL always go to SHIFT.
REQ-016 SHIFT SHALL arithmetic-shift the 67-bit value {A,Q,q_m1} right by 2 (sign of A[33] replicated) and SHALL increment cnt.
REQ-017 SHIFT SHALL go to DONE when cnt=15 before the increment, and to ADD otherwise (16 iterations in total).
REQ-018 On the transition into DONE, product SHALL be loaded with {A[31:0],Q}.
REQ-019 DONE SHALL always go to IDLE.
REQ-020 done SHALL be high only while the FSM is in DONE, i.e. exactly one cycle.
REQ-021 Latency: if start is accepted at edge N, done SHALL be high during the cycle after edge N+33.
REQ-022 product SHALL hold its value from DONE until the next DONE, and SHALL be unaffected by changes to X, Y or start.
REQ-023 Changes to start, X and Y while busy=1 SHALL be ignored.
REQ-024 A start that is high during DONE SHALL NOT be accepted there; it is accepted in the following IDLE cycle if still high.
REQ-025 A start held high continuously SHALL give back-to-back operations of 35 cycles each.
REQ-026 The result SHALL be exact for all 2^64 operand pairs, including -2^31 * -2^31 = +2^62.

Reset
REQ-027 While rst_b=0, the block SHALL asynchronously force:
- state = IDLE
- A, Q, M, q_m1, cnt = 0
- product = 0
- busy = 0, done = 0
REQ-028 Reset asserted mid-operation SHALL abort the operation with no done pulse; product SHALL read 0.
REQ-029 After rst_b deasserts, the first rising edge with start=1 SHALL be accepted.

Verification
REQ-030 X=4802, Y=172, one-cycle start -> done at N+33; product=64'h0000_0000_000C_9A58 (825944); busy high for 34 cycles.
REQ-031 X=32'hFFFF_FFFF, Y=1 -> product=64'hFFFF_FFFF_FFFF_FFFF; then X=0, Y=32'h7FFF_FFFF -> product=0.
REQ-032 X=Y=32'h8000_0000 -> product=64'h4000_0000_0000_0000; X=32'h7FFF_FFFF, Y=32'h8000_0000 -> product=64'hC000_0000_8000_0000.
REQ-033 Start with X=3, Y=5, then pulse start with X=7, Y=7 at edge N+10 -> single done at N+33 with product=15; no second done.
REQ-034 Start with X=3, Y=5, pull rst_b low at edge N+12 for 2 cycles -> busy=0, product=0 with no done; restart with X=-6, Y=7 -> product=64'hFFFF_FFFF_FFFF_FFD6.
REQ-035 Random regression of at least 10k signed pairs, including start held high continuously -> every product equals a 64-bit signed reference, with done spaced exactly 35 cycles apart.
